// File: rtl/midi_poly_dds_if.sv
// Voice-register write port, sample strobe and sample output bundle for midi_poly_dds.
interface midi_poly_dds_if #(
  parameter int unsigned VOICES  = 16,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned OUT_W   = 8
);
  localparam int unsigned VW = $clog2(VOICES);

  logic               i_wr_en;
  logic [VW-1:0]      i_wr_addr;
  logic               i_wr_note_en;
  logic [PHASE_W-1:0] i_wr_add_val;
  logic [6:0]         i_wr_vel;
  logic               i_tick;
  logic               o_busy;
  logic [OUT_W-1:0]   o_sample;
  logic               o_sample_vld;
  logic [VW:0]        o_active_cnt;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_note_en, i_wr_add_val, i_wr_vel, i_tick,
    input  o_busy, o_sample, o_sample_vld, o_active_cnt
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_note_en, i_wr_add_val, i_wr_vel, i_tick,
    output o_busy, o_sample, o_sample_vld, o_active_cnt
  );
endinterface

// File: rtl/midi_poly_dds.sv
// Time-multiplexed polyphonic square-wave DDS: one voice per cycle per sample tick,
// velocity-scaled outputs summed into one unsigned sample.
module midi_poly_dds #(
  parameter int unsigned VOICES  = 16,
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned VEL_EN  = 1
) (
  input  logic            i_clk,
  input  logic            i_res,
  midi_poly_dds_if.slave  bus
);
  localparam int unsigned VW    = $clog2(VOICES);
  localparam int unsigned ACC_W = 7 + VW;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_e;

  state_e             state_q;
  logic               note_en_q [VOICES];
  logic [PHASE_W-1:0] add_val_q [VOICES];
  logic [6:0]         vel_q     [VOICES];
  logic [PHASE_W-1:0] phase_q   [VOICES];

  logic [VW-1:0]      v_q;
  logic [ACC_W-1:0]   acc_q;
  logic [VW:0]        cnt_q;
  logic               busy_q;
  logic               vld_q;
  logic [OUT_W-1:0]   sample_q;
  logic [VW:0]        active_q;

  logic [PHASE_W-1:0] phase_d;
  logic [ACC_W-1:0]   acc_d;
  logic [VW:0]        cnt_d;
  logic [6:0]         amp;

  // Contribution of the voice currently addressed by the scan pointer.
  always_comb begin
    amp     = (VEL_EN != 0) ? vel_q[v_q] : 7'd127;
    phase_d = '0;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (note_en_q[v_q]) begin
      phase_d = phase_q[v_q] + add_val_q[v_q];
      cnt_d   = cnt_q + (VW+1)'(1);
      if (phase_d[PHASE_W-1]) begin
        acc_d = acc_q + ACC_W'(amp);
      end
    end
  end

  // Register file; the scan reads the pre-write value on a same-edge collision.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      for (int i = 0; i < VOICES; i++) begin
        note_en_q[i] <= 1'b0;
        add_val_q[i] <= '0;
        vel_q[i]     <= '0;
      end
    end else if (bus.i_wr_en) begin
      note_en_q[bus.i_wr_addr] <= bus.i_wr_note_en;
      add_val_q[bus.i_wr_addr] <= bus.i_wr_add_val;
      vel_q[bus.i_wr_addr]     <= bus.i_wr_vel;
    end
  end

  // Scan sequencer; the result is latched on the last voice so vld is high during DONE.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      state_q  <= ST_IDLE;
      v_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      sample_q <= '0;
      active_q <= '0;
      for (int i = 0; i < VOICES; i++) begin
        phase_q[i] <= '0;
      end
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_tick) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            v_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          phase_q[v_q] <= phase_d;
          acc_q        <= acc_d;
          cnt_q        <= cnt_d;
          v_q          <= v_q + VW'(1);
          if (v_q == VW'(VOICES - 1)) begin
            sample_q <= acc_d[ACC_W-1 -: OUT_W];
            active_q <= cnt_d;
            vld_q    <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_sample     = sample_q;
  assign bus.o_sample_vld = vld_q;
  assign bus.o_active_cnt = active_q;
endmodule
